down_counter_fsm: RTL and testbench

DOWN_COUNTER_FSM -- requirements
Module: down_counter_fsm

---
 rtl/down_counter_fsm_pkg.sv | 12 +
 rtl/sub_by_one.sv | 24 ++
 rtl/down_counter_fsm.sv | 94 +++++++++
 tb/tb_down_counter_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/down_counter_fsm_pkg.sv
// Shared types and constants for the down-counter FSM and its decrementer.
package down_counter_fsm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sub_by_one.sv
// Borrow-ripple decrementer: a chain of one-bit half-subtractor cells.
module sub_by_one
  import down_counter_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             bin,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign out[i]        = in[i] ^ borrow[i];
    assign borrow[i + 1] = ~in[i] & borrow[i];
  end

  assign bout = borrow[WIDTH];

endmodule

// File: rtl/down_counter_fsm.sv
// Loadable down counter with wrap/stop terminal behaviour, borrow pulse and
// a one-cycle done indication.
module down_counter_fsm
  import down_counter_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             bout,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic             bout_next;
  logic             dec_bin;
  logic [WIDTH-1:0] dec_out;
  logic             dec_bout;

  assign dec_bin = en & (state == COUNT);

  sub_by_one #(
    .WIDTH(WIDTH)
  ) u_sub_by_one (
    .in  (count),
    .bin (dec_bin),
    .out (dec_out),
    .bout(dec_bout)
  );

  // Borrow-out of the decrementer marks the decrement from zero.
  always_comb begin
    state_next = state;
    count_next = count;
    bout_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          count_next = load_val;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (load) begin
          count_next = load_val;
        end else if (en) begin
          bout_next = dec_bout;
          if (dec_bout && !wrap) begin
            state_next = DONE;
          end else begin
            count_next = dec_out;
          end
        end
      end
      DONE: begin
        if (load) begin
          count_next = load_val;
          state_next = COUNT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      bout  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      bout  <= bout_next;
      done  <= (state_next == DONE);
      busy  <= (state_next == COUNT);
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_fsm.sv
// Directed plus randomized check of down_counter_fsm against a cycle model.
module tb_down_counter_fsm;

  localparam int unsigned W   = 4;
  localparam int          MAX = (1 << W) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_COUNT = 1;
  localparam int PH_DONE  = 2;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         wrap;
  logic [W-1:0] count;
  logic         zero;
  logic         busy;
  logic         bout;
  logic         done;

  int checks = 0;
  int errors = 0;

  int m_phase;
  int m_count;
  int m_bout;

  down_counter_fsm #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .wrap    (wrap),
    .count   (count),
    .zero    (zero),
    .busy    (busy),
    .bout    (bout),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".zero"},  32'(zero),  32'(m_count == 0));
    check({tag, ".busy"},  32'(busy),  32'(m_phase == PH_COUNT));
    check({tag, ".bout"},  32'(bout),  32'(m_bout));
    check({tag, ".done"},  32'(done),  32'(m_phase == PH_DONE));
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_count = 0;
    m_bout  = 0;
  endtask

  // One clock of the behaviour as described by the rules, in plain arithmetic.
  task automatic model_edge(input int ld, input int lv, input int e, input int wr);
    m_bout = 0;
    if (m_phase == PH_IDLE) begin
      if (ld != 0) begin
        m_count = lv;
        m_phase = PH_COUNT;
      end
    end else if (m_phase == PH_COUNT) begin
      if (ld != 0) begin
        m_count = lv;
      end else if (e != 0) begin
        if (m_count == 0) begin
          m_bout = 1;
          if (wr != 0) m_count = MAX;
          else m_phase = PH_DONE;
        end else begin
          m_count = (m_count - 1) % (MAX + 1);
        end
      end
    end else begin
      if (ld != 0) begin
        m_count = lv;
        m_phase = PH_COUNT;
      end else begin
        m_phase = PH_IDLE;
      end
    end
  endtask

  task automatic step(input string tag, input int ld, input int lv, input int e, input int wr);
    load     = ld[0];
    load_val = lv[W-1:0];
    en       = e[0];
    wrap     = wr[0];
    @(posedge clk);
    model_edge(ld, lv, e, wr);
    #1;
    check_all(tag);
  endtask

  // Async reset between edges, checked while held, released away from the edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    wrap     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("idle_en_ignored", 0, 0, 1, 0);

    // Stop at zero: 3,2,1,0 then DONE with borrow, then IDLE.
    step("stop_load", 1, 3, 1, 0);
    for (int i = 0; i < 3; i++) step("stop_dec", 0, 0, 1, 0);
    step("stop_done", 0, 0, 1, 0);
    step("stop_idle", 0, 0, 1, 0);

    // Wrap: 1,0,15,14 with borrow only at 15.
    step("wrap_load", 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("wrap_dec", 0, 0, 1, 1);

    // Load has priority over en.
    step("prio_load9", 1, 9, 0, 0);
    step("prio_load6", 1, 6, 1, 0);

    // en toggling from 5.
    step("tog_load5", 1, 5, 0, 0);
    step("tog_en1", 0, 0, 1, 0);
    step("tog_en0", 0, 0, 0, 0);
    step("tog_en1b", 0, 0, 1, 0);

    // Async reset at count 7, no done afterwards.
    step("rst_load8", 1, 8, 0, 0);
    step("rst_dec7", 0, 0, 1, 0);
    async_reset("rst_mid");
    step("rst_after1", 0, 0, 1, 0);
    step("rst_after2", 0, 0, 1, 0);

    // Reload in DONE goes straight back to COUNT.
    step("done_load0", 1, 0, 0, 0);
    step("done_enter", 0, 0, 1, 0);
    step("done_reload", 1, 2, 1, 0);
    step("done_count", 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 7) == 0) ? 1 : 0,
             int'($urandom_range(0, MAX)),
             ($urandom_range(0, 3) != 0) ? 1 : 0,
             int'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
